// File: rtl/enc8to3_seq.sv
// Sequential 8-to-3 encoder: captures a request vector on load, then emits the index of
// every set bit in ascending order over valid/ready. Optional err port: ENC_ZERO_ERR_EN.
module enc8to3_seq (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] req_i,
    input  logic       load_i,
    input  logic       ready_i,
    output logic [2:0] code_o,
    output logic       valid_o,
    output logic       last_o,
    output logic       busy_o,
    output logic       done_o
`ifdef ENC_ZERO_ERR_EN
    ,
    output logic       err_o
`endif
);

    typedef enum logic {StIdle, StEmit} state_e;

    state_e     state_q, state_d;
    logic [7:0] pend_q, pend_d;
    logic [2:0] code_q, code_d;
    logic       valid_q, valid_d;
    logic       last_q, last_d;
    logic       done_q, done_d;
`ifdef ENC_ZERO_ERR_EN
    logic       err_q, err_d;
`endif

    function automatic logic [2:0] lowest_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    function automatic logic is_onehot(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        done_d  = 1'b0;
`ifdef ENC_ZERO_ERR_EN
        err_d   = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (load_i) begin
                    if (req_i != 8'd0) begin
                        pend_d  = req_i;
                        state_d = StEmit;
                    end else begin
                        done_d = 1'b1;
`ifdef ENC_ZERO_ERR_EN
                        err_d  = 1'b1;
`endif
                    end
                end
            end
            StEmit: begin
                if (ready_i) begin
                    // Drop the lowest set bit: the code just accepted.
                    pend_d = pend_q & (pend_q - 8'd1);
                    if (pend_d == 8'd0) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        // Outputs are registered from the next state so nothing depends on inputs.
        code_d  = lowest_idx(pend_d);
        valid_d = (state_d == StEmit);
        last_d  = (state_d == StEmit) && is_onehot(pend_d);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            pend_q  <= 8'd0;
            code_q  <= 3'd0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ENC_ZERO_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
`ifdef ENC_ZERO_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    assign code_o  = code_q;
    assign valid_o = valid_q;
    assign busy_o  = valid_q;
    assign last_o  = last_q;
    assign done_o  = done_q;
`ifdef ENC_ZERO_ERR_EN
    assign err_o   = err_q;
`endif

endmodule

// File: tb/tb_enc8to3_seq.sv
// Self-checking bench for enc8to3_seq: queue-based model checked every negedge,
// plus directed scenarios with literal expectations and a randomized phase.
module tb_enc8to3_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       load;
    logic       ready;
    logic [2:0] code;
    logic       valid;
    logic       last;
    logic       busy;
    logic       done;
`ifdef ENC_ZERO_ERR_EN
    logic       err;
`endif

    int errors = 0;
    int checks = 0;

    // Model: queue of indices still to be emitted, plus pending pulses.
    int q[$];
    bit done_m = 1'b0;
    bit err_m  = 1'b0;

    always #5 clk = ~clk;

    enc8to3_seq dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .req_i   (req),
        .load_i  (load),
        .ready_i (ready),
        .code_o  (code),
        .valid_o (valid),
        .last_o  (last),
        .busy_o  (busy),
        .done_o  (done)
`ifdef ENC_ZERO_ERR_EN
        ,
        .err_o   (err)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Inputs change only right after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_st(input string tag, input bit v, input int c, input bit l, input bit d);
        @(negedge clk);
        chk({tag, ".valid"}, int'(valid), int'(v));
        chk({tag, ".busy"}, int'(busy), int'(v));
        chk({tag, ".last"}, int'(last), int'(l));
        chk({tag, ".done"}, int'(done), int'(d));
        if (v) chk({tag, ".code"}, int'(code), c);
    endtask

    // Compare process: check against the model, then advance it with the current inputs.
    initial begin
        bit dn, en;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                done_m = 1'b0;
                err_m  = 1'b0;
            end
            chk("m.valid", int'(valid), int'(q.size() != 0));
            chk("m.busy", int'(busy), int'(q.size() != 0));
            chk("m.last", int'(last), int'(q.size() == 1));
            if (q.size() != 0) chk("m.code", int'(code), q[0]);
            chk("m.done", int'(done), int'(done_m));
`ifdef ENC_ZERO_ERR_EN
            chk("m.err", int'(err), int'(err_m));
`endif
            if (!rst) begin
                dn = 1'b0;
                en = 1'b0;
                if (q.size() == 0) begin
                    if (load) begin
                        if (req == 8'd0) begin
                            dn = 1'b1;
                            en = 1'b1;
                        end else begin
                            for (int i = 0; i < 8; i++) if (req[i]) q.push_back(i);
                        end
                    end
                end else if (ready) begin
                    void'(q.pop_front());
                    if (q.size() == 0) dn = 1'b1;
                end
                done_m = dn;
                err_m  = en;
            end
        end
    end

    initial begin
        rst   = 1'b1;
        req   = 8'd0;
        load  = 1'b0;
        ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst.code", int'(code), 0);
        expect_st("rst", 1'b0, 0, 1'b0, 1'b0);
`ifdef ENC_ZERO_ERR_EN
        chk("rst.err", int'(err), 0);
`endif
        tick();
        rst = 1'b0;

        // Ascending emission, last on the final code.
        tick();
        req = 8'b1010_0100; load = 1'b1; ready = 1'b1;
        tick();
        load = 1'b0;
        expect_st("a4.c0", 1'b1, 2, 1'b0, 1'b0);
        tick(); expect_st("a4.c1", 1'b1, 5, 1'b0, 1'b0);
        tick(); expect_st("a4.c2", 1'b1, 7, 1'b1, 1'b0);
        tick(); expect_st("a4.done", 1'b0, 0, 1'b0, 1'b1);
        tick(); expect_st("a4.idle", 1'b0, 0, 1'b0, 1'b0);

        // Backpressure holds code/valid stable.
        tick();
        req = 8'h81; load = 1'b1; ready = 1'b0;
        tick();
        load = 1'b0;
        expect_st("81.h0", 1'b1, 0, 1'b0, 1'b0);
        tick(); expect_st("81.h1", 1'b1, 0, 1'b0, 1'b0);
        tick(); ready = 1'b1;
        expect_st("81.h2", 1'b1, 0, 1'b0, 1'b0);
        tick(); expect_st("81.c1", 1'b1, 7, 1'b1, 1'b0);
        tick(); expect_st("81.done", 1'b0, 0, 1'b0, 1'b1);

        // Empty load: done (and err) only.
        tick();
        req = 8'h00; load = 1'b1;
        tick();
        load = 1'b0;
        expect_st("zero.done", 1'b0, 0, 1'b0, 1'b1);
`ifdef ENC_ZERO_ERR_EN
        chk("zero.err", int'(err), 1);
`endif
        tick(); expect_st("zero.after", 1'b0, 0, 1'b0, 1'b0);

        // Load during EMIT ignored; load in the done cycle accepted.
        tick();
        req = 8'h03; load = 1'b1; ready = 1'b1;
        tick();
        req = 8'hF0; load = 1'b1;
        expect_st("03.c0", 1'b1, 0, 1'b0, 1'b0);
        tick();
        load = 1'b0;
        expect_st("03.c1", 1'b1, 1, 1'b1, 1'b0);
        tick();
        load = 1'b1;
        expect_st("03.done", 1'b0, 0, 1'b0, 1'b1);
        tick();
        load = 1'b0;
        expect_st("f0.c0", 1'b1, 4, 1'b0, 1'b0);
        tick(); expect_st("f0.c1", 1'b1, 5, 1'b0, 1'b0);
        tick(); expect_st("f0.c2", 1'b1, 6, 1'b0, 1'b0);
        tick(); expect_st("f0.c3", 1'b1, 7, 1'b1, 1'b0);
        tick(); expect_st("f0.done", 1'b0, 0, 1'b0, 1'b1);

        // Full vector, one code per cycle.
        tick();
        req = 8'hFF; load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            expect_st($sformatf("ff.c%0d", i), 1'b1, i, (i == 7), 1'b0);
            tick();
        end
        expect_st("ff.done", 1'b0, 0, 1'b0, 1'b1);

        // Asynchronous reset mid-burst.
        tick();
        req = 8'h3C; load = 1'b1;
        tick();
        load = 1'b0;
        expect_st("3c.c0", 1'b1, 2, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.valid", int'(valid), 0);
        chk("arst.busy", int'(busy), 0);
        chk("arst.code", int'(code), 0);
        @(negedge clk);
        tick();
        rst = 1'b0;
        req = 8'h10; load = 1'b1;
        tick();
        load = 1'b0;
        expect_st("10.c0", 1'b1, 4, 1'b1, 1'b0);
        tick(); expect_st("10.done", 1'b0, 0, 1'b0, 1'b1);

        // Randomized traffic, checked by the model.
        for (int n = 0; n < 2000; n++) begin
            tick();
            rst   = ($urandom_range(0, 149) == 0);
            load  = ($urandom_range(0, 3) == 0);
            req   = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            ready = ($urandom_range(0, 3) != 0);
        end
        tick();
        rst  = 1'b0;
        load = 1'b0;
        @(negedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/enc8to3_seq.md
# enc8to3_seq

Sequential 8-to-3 encoder, the encoding end of our 3-to-8 decoder path. It captures an 8-bit request vector on `load`, then emits the 3-bit index of every set bit in ascending order over a valid/ready handshake, one index per accepted transfer. Downstream it feeds a 3-to-8 decoder stage or any consumer of binary line indices. An optional error flag reports loads with an empty request vector.

## Interface
Parameters: none. Widths are fixed at 8 request lines and a 3-bit code.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous reset, active-high.
- `req`  in  8  request vector; sampled only when a load is accepted.
- `load`  in  1  capture `req` and start a burst; honoured only in IDLE.
- `ready`  in  1  consumer accepts `code` this cycle.
- `code`  out  3  index of the lowest pending set bit.
- `valid`  out  1  `code` is meaningful.
- `last`  out  1  with `valid`: the current code is the final one of the burst.
- `busy`  out  1  burst in progress (state EMIT).
- `done`  out  1  one-cycle pulse at burst end.
- `err`  out  1  present only with `ENC_ZERO_ERR_EN`; one-cycle pulse.

Clocking and reset: one clock; reset is asynchronous and active-high.

## Operation
- State: a 2-state FSM (IDLE, EMIT) plus an 8-bit pending register `pend`.
- `code` is the lowest set bit index of `pend`.
- `valid` equals `busy`, which equals (state == EMIT).
- `last` is high when `pend` has exactly one bit set and state is EMIT.
- All outputs derive from registered state only. There is no combinational path from `req`, `load` or `ready` to any output.
- IDLE with `load`=1 and `req`≠0: `pend` ← `req`; next state EMIT.
- IDLE with `load`=1 and `req`=0: stay in IDLE; `done` pulses the next cycle. `err` also pulses the next cycle if the macro is compiled in.
- IDLE with `load`=0: hold.
- EMIT with `valid`&`ready`: clear the lowest set bit of `pend`.
  - If that leaves `pend`=0: go to IDLE and pulse `done` the next cycle.
  - Otherwise: stay in EMIT. `code` advances to the next set bit on the next cycle.
- EMIT with `ready`=0: hold `pend`; `code`, `valid` and `last` stay stable.
- `load` in EMIT is ignored. `req` changes in EMIT have no effect.
- A `load` in the same cycle as `done`=1 is accepted (the FSM is in IDLE).
- Reset values: state IDLE, `pend`=0, `code`=0, `valid`=0, `last`=0, `busy`=0, `done`=0, `err`=0.

## Timing
- Load accepted at edge N: `valid` is high from edge N through the cycle after it; first handshake is possible in cycle N+1.
- Throughput is one code per cycle while `ready`=1. A request vector with k set bits (k≥1) takes k cycles from first `valid` to last handshake.
- `done` is high for exactly the one cycle after the final handshake, or the one cycle after an empty load.
- `rst` assertion clears all state and outputs immediately, without waiting for a clock edge, including mid-burst. Any in-flight codes are discarded. The first load is honoured on the first rising edge after `rst` deasserts.

## Configuration
- `ENC_ZERO_ERR_EN` defined: port `err` exists. It pulses for one cycle, coincident with `done`, after a load with `req`=0.
- `ENC_ZERO_ERR_EN` undefined: no `err` port. An empty load only pulses `done`.
- All other behaviour is identical in both builds.

## Test plan
- `req`=8'b1010_0100, one-cycle `load`, `ready`=1: `code` is 2, 5, 7 on three consecutive cycles. `last`=1 only with 7. `done`=1 the next cycle, and `busy`=0 from then.
- `req`=8'h81, `ready`=0 for 3 cycles: `code`=0 and `valid`=1 are held stable for all 3 cycles. Then `ready`=1 gives 0 then 7, then `done`.
- `req`=8'h00 with `load`: `valid` never rises and `done`=1 one cycle later. With the macro, `err`=1 in the same cycle; without it, there is no `err` port.
- Burst on 8'h03; assert `load` with `req`=8'hF0 mid-burst: only 0 and 1 are emitted. A reload with 8'hF0 in the `done` cycle is accepted and emits 4, 5, 6, 7.
- `req`=8'hFF, `ready`=1: codes 0..7 on 8 consecutive cycles, `last` on 7.
- `rst` pulsed asynchronously mid-burst of 8'h3C: `valid`, `busy` and `code` read 0 before the next edge. After release, a load of 8'h10 yields code 4.
